// File: rtl/svm_mc.sv
// svm_mc: multi-class linear SVM scorer fed by the HOG feature pipeline.
// Accepts N_FEA features per slide window, runs N_CLASS dot products in
// parallel against a host-loaded coefficient RAM, adds a per-class bias and
// picks the winner by sequential argmax.
// Optional feature: define SVM_SCORE_SAT_EN to report o_score as a saturated
// FEA_W-wide value (score >> FEA_F) instead of the raw accumulator width.
module svm_mc #(
   parameter  int FEA_I   = 4,
   parameter  int FEA_F   = 8,
   parameter  int N_CLASS = 4,
   parameter  int N_FEA   = 3780,
   parameter  int SW_W    = 11,
   localparam int FEA_W   = FEA_I + FEA_F,
   localparam int CLS_W   = $clog2(N_CLASS),
   localparam int ADDR_W  = $clog2(N_FEA),
   localparam int ACC_W   = 2*FEA_W + $clog2(N_FEA),
`ifdef SVM_SCORE_SAT_EN
   localparam int OUT_W   = FEA_W
`else
   localparam int OUT_W   = ACC_W
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     i_ready,
   input  logic [FEA_W-1:0]         fea,
   input  logic [ADDR_W-1:0]        c_addr,
   input  logic                     c_wen,
   input  logic [N_CLASS*FEA_W-1:0] c_wdata,
   output logic [N_CLASS*FEA_W-1:0] c_rdata,
   input  logic [FEA_W-1:0]         bias,
   input  logic [CLS_W-1:0]         b_sel,
   input  logic                     b_load,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic [CLS_W-1:0]         o_class,
   output logic [OUT_W-1:0]         o_score,
   output logic                     o_hit,
   output logic [SW_W-1:0]          sw_id
);

   typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_ARG, S_OUT} state_t;

   localparam logic [ADDR_W-1:0] LAST_FEA = ADDR_W'(N_FEA-1);
   localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(N_CLASS-1);

   state_t                   r_state, w_next;
   logic                     w_in_rdy, w_accept, w_last_fea, w_arg_last, w_out_hs;
   logic [ADDR_W-1:0]        r_fea_cnt;
   logic                     r_drain;
   logic [CLS_W-1:0]         r_arg_idx;

   logic [N_CLASS*FEA_W-1:0] r_mem [N_FEA];
   logic [N_CLASS*FEA_W-1:0] r_coef;
   logic [N_CLASS*FEA_W-1:0] r_c_rdata;
   logic [FEA_W-1:0]         r_fea_d;
   logic                     r_mac_vld;
   logic signed [ACC_W-1:0]  w_acc [N_CLASS];
   logic [FEA_W-1:0]         r_bias [N_CLASS];

   logic signed [ACC_W-1:0]  w_bias_ext, w_score, w_win_score, r_best;
   logic [CLS_W-1:0]         w_win_cls, r_best_cls;
   logic                     w_take, w_win_hit;
   logic [OUT_W-1:0]         w_out_score;

   logic [CLS_W-1:0]         r_o_class;
   logic [OUT_W-1:0]         r_o_score;
   logic                     r_o_hit;
   logic [SW_W-1:0]          r_sw;

   assign w_in_rdy   = (r_state == S_IDLE) || (r_state == S_ACC);
   assign w_accept   = i_valid && w_in_rdy;
   assign w_last_fea = (r_fea_cnt == LAST_FEA);
   assign w_arg_last = (r_arg_idx == LAST_CLS);
   assign w_out_hs   = (r_state == S_OUT) && o_ready;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_last_fea ? S_DRAIN : S_ACC;
         S_ACC:   if (w_accept && w_last_fea) w_next = S_DRAIN;
         S_DRAIN: if (r_drain) w_next = S_ARG;
         S_ARG:   if (w_arg_last) w_next = S_OUT;
         S_OUT:   if (o_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // two-cycle drain: one for the last RAM read, one for the last MAC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_drain <= 1'b0;
      else      r_drain <= (r_state == S_DRAIN) && !r_drain;
   end

   // coefficient RAM: host write port plus the feature-indexed read port;
   // contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (c_wen) r_mem[c_addr] <= c_wdata;
      r_coef <= r_mem[r_fea_cnt];
   end

   // host readback port; a same-cycle write returns the old word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_c_rdata <= '0;
      else      r_c_rdata <= r_mem[c_addr];
   end

   // feature index and one-cycle feature delay to line up with r_coef
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fea_cnt <= '0;
         r_fea_d   <= '0;
         r_mac_vld <= 1'b0;
      end else begin
         r_mac_vld <= w_accept;
         if (w_accept) begin
            r_fea_d   <= fea;
            r_fea_cnt <= w_last_fea ? '0 : r_fea_cnt + 1'b1;
         end
      end
   end

   // per-class MAC lanes
   for (genvar k = 0; k < N_CLASS; k++) begin : g_cls
      logic signed [FEA_W-1:0]   w_c;
      logic signed [2*FEA_W-1:0] w_prod;
      logic signed [ACC_W-1:0]   r_acc;

      assign w_c    = r_coef[k*FEA_W +: FEA_W];
      assign w_prod = $signed(r_fea_d) * w_c;
      assign w_acc[k] = r_acc;

      // accumulate, cleared when the result handshake returns us to IDLE
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)           r_acc <= '0;
         else if (w_out_hs)  r_acc <= '0;
         else if (r_mac_vld) r_acc <= r_acc + ACC_W'(w_prod);
      end
   end

   // bias registers, writable in any state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N_CLASS; k++) r_bias[k] <= '0;
      end else if (b_load) begin
         r_bias[b_sel] <= bias;
      end
   end

   // argmax step: class 0 seeds the best; strict '>' keeps the lower index on ties
   assign w_bias_ext  = ACC_W'($signed(r_bias[r_arg_idx]));
   assign w_score     = w_acc[r_arg_idx] + (w_bias_ext <<< FEA_F);
   assign w_take      = (r_arg_idx == '0) || (w_score > r_best);
   assign w_win_score = w_take ? w_score : r_best;
   assign w_win_cls   = w_take ? r_arg_idx : r_best_cls;
   assign w_win_hit   = !w_win_score[ACC_W-1] && (w_win_score != '0);

`ifdef SVM_SCORE_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(FEA_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(FEA_W-1)));
   logic signed [ACC_W-1:0] w_shift;
   assign w_shift     = w_win_score >>> FEA_F;
   assign w_out_score = (w_shift > SAT_HI) ? FEA_W'(SAT_HI) :
                        (w_shift < SAT_LO) ? FEA_W'(SAT_LO) : FEA_W'(w_shift);
`else
   assign w_out_score = w_win_score;
`endif

   // argmax sweep and result capture on the last class
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_arg_idx  <= '0;
         r_best     <= '0;
         r_best_cls <= '0;
         r_o_class  <= '0;
         r_o_score  <= '0;
         r_o_hit    <= 1'b0;
      end else if (r_state == S_ARG) begin
         r_arg_idx  <= w_arg_last ? '0 : r_arg_idx + 1'b1;
         r_best     <= w_win_score;
         r_best_cls <= w_win_cls;
         if (w_arg_last) begin
            r_o_class <= w_win_cls;
            r_o_score <= w_out_score;
            r_o_hit   <= w_win_hit;
         end
      end
   end

   // slide window index advances on each delivered result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_sw <= '0;
      else if (w_out_hs) r_sw <= r_sw + 1'b1;
   end

   assign i_ready = w_in_rdy;
   assign o_valid = (r_state == S_OUT);
   assign o_class = r_o_class;
   assign o_score = r_o_score;
   assign o_hit   = r_o_hit;
   assign sw_id   = r_sw;
   assign c_rdata = r_c_rdata;

endmodule

// File: doc/svm_mc.md
Name: svm_mc

Overview:
- Parametrised multi-class successor to the single-class SVM scorer that sits behind the HOG feature pipeline.
- Consumes a window-major stream of HOG features (N_FEA per slide window) and computes N_CLASS linear dot products in parallel against a host-loaded coefficient RAM.
- Adds a per-class bias, resolves the winning class by sequential argmax, and presents class, score, hit flag and slide-window index on a valid/ready output.
- Adds input back-pressure, which the previous scorer lacked.

Parameters:
- FEA_I, 4: integer bits of feature and coefficient (signed two's complement, FEA_W = FEA_I + FEA_F).
- FEA_F, 8: fractional bits of feature and coefficient.
- N_CLASS, 4: number of classes, range 2..16. CLS_W = clog2(N_CLASS).
- N_FEA, 3780: features per slide window. ADDR_W = clog2(N_FEA).
- SW_W, 11: slide window index width.
- Derived: ACC_W = 2*FEA_W + clog2(N_FEA), fraction 2*FEA_F.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  feature valid.
- i_ready  out  1  block accepts a feature this cycle.
- fea  in  FEA_W  signed feature.
- c_addr  in  ADDR_W  coefficient RAM host address.
- c_wen  in  1  coefficient write enable.
- c_wdata  in  N_CLASS*FEA_W  coefficients, class k at bits [k*FEA_W +: FEA_W].
- c_rdata  out  N_CLASS*FEA_W  registered host readback of c_addr.
- bias  in  FEA_W  signed bias value.
- b_sel  in  CLS_W  bias target class.
- b_load  in  1  load bias into class b_sel.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- o_class  out  CLS_W  winning class.
- o_score  out  OUT_W  winning score. OUT_W = ACC_W by default; see Optional Feature.
- o_hit  out  1  winning score strictly > 0.
- sw_id  out  SW_W  index of the window the result belongs to.

Behaviour:
- Reset: all outputs 0; state IDLE; fea_cnt, accumulators, bias registers and sw counter cleared. RAM contents are not reset. Reset mid-window discards the partial window and returns to IDLE; the next accepted feature is index 0.
- i_ready = 1 in IDLE and ACC, 0 in DRAIN, ARG and OUT. A feature is accepted when i_valid & i_ready.
- FSM:
  - IDLE -> ACC on the first accepted feature.
  - ACC stays until the feature with fea_cnt = N_FEA-1 is accepted, then -> DRAIN.
  - DRAIN lasts 2 cycles (RAM read plus MAC) -> ARG.
  - ARG lasts N_CLASS cycles, comparing one class per cycle -> OUT.
  - OUT holds until o_valid & o_ready -> IDLE.
- RAM: dual-port. The internal read address is fea_cnt; read latency is 1 cycle. The feature is delayed 1 cycle to align with its coefficient. MAC: acc_k += fea * coef_k, signed, full ACC_W, no overflow possible.
- ARG step k: score_k = acc_k + (bias_k sign-extended, << FEA_F).
  - Replace the current best if score_k > best.
  - Ties keep the lower class index.
  - Class 0 initialises best.
- Latency: o_valid rises N_CLASS+3 cycles after the cycle accepting the last feature of a window.
- Output hold: o_class, o_score, o_hit and sw_id stay stable while o_valid & !o_ready. o_valid drops the cycle after the handshake.
- Window counter: sw_id increments on each output handshake and wraps from 2^SW_W-1 to 0.
- Accumulators clear on the transition into IDLE, so the next window starts from 0 with no bubble beyond the OUT handshake.
- Host writes:
  - c_wen writes c_wdata at c_addr in any state.
  - A write during ACC to an address not yet read affects the current window; this is the host's responsibility.
  - c_rdata is valid 1 cycle after c_addr is presented.
  - A simultaneous write and read of the same address returns the old data.
- b_load updates the bias register in any state. A load during ARG takes effect for classes not yet evaluated.

Optional Feature:
- SVM_SCORE_SAT_EN defined: OUT_W = FEA_W. o_score = score >> FEA_F (arithmetic), saturated to [-2^(FEA_W-1), 2^(FEA_W-1)-1]. o_hit and argmax still use the full-precision score.
- Undefined: OUT_W = ACC_W, with the raw score at fraction 2*FEA_F.

Test Plan:
- Basic decision (N_CLASS=2, N_FEA=4): features 0x100 x4; class0 coef 0x080, class1 coef 0xFC0; bias0 0, bias1 0xF00. Expect o_class=0, o_score=0x20000 (2.0), o_hit=1, sw_id=0, o_valid 5 cycles after the last feature.
- Tie and negative: both classes coef 0xF80, biases 0. Expect o_class=0, o_score = -2.0 (0x...E0000 sign-extended), o_hit=0.
- Back-pressure: hold o_ready=0 for 5 cycles. Expect o_valid and outputs stable and i_ready=0 throughout; after the handshake, the next window reports sw_id=1. Run 2^SW_W+1 windows and check sw_id wraps to 0.
- Reset mid-window: assert rst after 2 features, release, send 4 features. Expect a single result equal to the 4-feature window only, with sw_id=0.
- Host interface: write coef at addr 3, read back next cycle; b_load bias 0x100 to class 1 during ACC; check score1 includes +1.0.
- SVM_SCORE_SAT_EN: features 0x7FF, coefs 0x7FF. Expect o_score=0x7FF and o_hit=1. With features 0x800 and coefs 0x7FF, expect o_score=0x800.
